// File: rtl/lfsr_range_sampler.sv
// Turns free-running LFSR words into unbiased values in [0, limit) by mask-and-reject sampling,
// buffered in a first-word-fall-through FIFO. Define LFSR_SAMPLER_STATS_EN to add rej_count.
module lfsr_range_sampler #(
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  num,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [OUT_W-1:0] cfg_limit,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LFSR_SAMPLER_STATS_EN
  output logic [15:0]      rej_count,
`endif
  output logic             busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StCfg, StRun} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] limit_q, mask_q, mask_calc, lim_m1;
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [OUT_W-1:0] last_q;
  logic [OUT_W-1:0] cand;
  logic             sample, in_range, full, push, pop, seen;

  if (IN_W > OUT_W) begin : g_unused_num
    logic unused_num_hi;
    assign unused_num_hi = ^num[IN_W-1:OUT_W];
  end

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = StCfg;
    end else begin
      unique case (state_q)
        StIdle, StCfg, StRun: state_d = enable ? StRun : StIdle;
        default:              state_d = StIdle;
      endcase
    end
  end

  // Smear the highest set bit of limit-1 downwards: limit 0 wraps to all ones, limit 1 gives 0.
  always_comb begin
    lim_m1    = limit_q - 1'b1;
    mask_calc = '0;
    seen      = 1'b0;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      seen         = seen | lim_m1[i];
      mask_calc[i] = seen;
    end
  end

  assign cand      = num[OUT_W-1:0] & mask_q;
  assign sample    = (state_q == StRun) && enable && !cfg_load;
  assign in_range  = (limit_q == '0) || (cand < limit_q);
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready && !cfg_load;
  assign push      = sample && in_range && (!full || pop);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : last_q;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      limit_q  <= '0;
      mask_q   <= '1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      state_q <= state_d;
      // Keeps out_data on the last head once the FIFO drains or is flushed.
      last_q  <= out_data;
      if (cfg_load) limit_q <= cfg_limit;
      if (state_q == StCfg) mask_q <= mask_calc;
      if (cfg_load) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

`ifdef LFSR_SAMPLER_STATS_EN
  logic [15:0] rej_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_q <= '0;
    end else if (cfg_load) begin
      rej_q <= '0;
    end else if (sample && !in_range && (rej_q != 16'hFFFF)) begin
      rej_q <= rej_q + 16'd1;
    end
  end

  assign rej_count = rej_q;
`endif

endmodule
